// File: rtl/enigma_decoder_if.sv
// Bus bundle between the Enigma receive-side decoder and its host.
// The master side drives vault writes and decode requests; the slave
// side (the decoder) returns status and the plaintext.
interface enigma_decoder_if;
    logic        store;
    logic [79:0] store_code;
    logic [7:0]  store_key;
    logic        start;
    logic [79:0] code_in;
    logic [7:0]  key;
    logic        busy;
    logic        done;
    logic        ok;
    logic [79:0] code_out;
    logic [1:0]  tries_left;
    logic        locked;

    modport master (
        output store, store_code, store_key, start, code_in, key,
        input  busy, done, ok, code_out, tries_left, locked
    );

    modport slave (
        input  store, store_code, store_key, start, code_in, key,
        output busy, done, ok, code_out, tries_left, locked
    );
endinterface

// File: rtl/enigma_decoder.sv
// Enigma receive-side decoder.
// Ciphertexts registered in a small vault (code + key) may be decoded;
// the vault is searched one entry per cycle, then the 10 bytes are decoded
// one per cycle from byte 9 down to byte 0 using a running 6-bit chain.
// Optional macro ENIGMA_DEC_LOCKOUT_EN compiles in failure counting,
// tries_left tracking and the absorbing LOCKED state.
module enigma_decoder #(
    parameter int DEPTH     = 10,
    parameter int MAX_TRIES = 3
) (
    input logic             msclk,
    input logic             rst,
    enigma_decoder_if.slave bus
);
    localparam int               IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [5:0]       PREV_INIT = 6'd5;

`ifdef ENIGMA_DEC_LOCKOUT_EN
    typedef enum logic [2:0] {S_IDLE, S_SEARCH, S_DECODE, S_DONE, S_LOCKED} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_SEARCH, S_DECODE, S_DONE} state_t;
`endif

    // Plaintext byte: zero ciphertext bytes pass through, others are
    // unchained modulo 64 against the previous plaintext and the key.
    function automatic logic [7:0] dec_byte(input logic [7:0] c,
                                            input logic [5:0] prev,
                                            input logic [5:0] k);
        logic [5:0] p;
        p = c[5:0] - prev - k;
        return (c == 8'd0) ? 8'd0 : {2'b00, p};
    endfunction

    state_t            state_q;
    logic [DEPTH-1:0]  vld_q;
    logic [79:0]       vcode_q [DEPTH];
    logic [7:0]        vkey_q  [DEPTH];
    logic [IDX_W-1:0]  wptr_q;
    logic [IDX_W-1:0]  idx_q;
    logic [3:0]        bidx_q;
    logic [79:0]       lcode_q;
    logic [7:0]        lkey_q;
    logic [5:0]        prev_q;
    logic [79:0]       word_q;
    logic              busy_q;
    logic              done_q;
    logic              ok_q;
    logic [79:0]       code_out_q;
`ifdef ENIGMA_DEC_LOCKOUT_EN
    logic [1:0]        tries_q;
    logic              locked_q;
`endif

    logic              hit_d;
    logic [7:0]        cbyte_d;
    logic [7:0]        pbyte_d;
    logic [79:0]       word_d;

    // Vault hit test for the current index and the byte being decoded
    always_comb begin
        hit_d   = vld_q[idx_q] && (vcode_q[idx_q] == lcode_q) && (vkey_q[idx_q] == lkey_q);
        cbyte_d = lcode_q[{bidx_q, 3'b000} +: 8];
        pbyte_d = dec_byte(cbyte_d, prev_q, lkey_q[5:0]);
        word_d  = word_q;
        word_d[{bidx_q, 3'b000} +: 8] = pbyte_d;
    end

    // Vault payload, latched operands and decode chain (no reset needed)
    always_ff @(posedge msclk) begin
        if (bus.store) begin
            vcode_q[wptr_q] <= bus.store_code;
            vkey_q[wptr_q]  <= bus.store_key;
        end
        if ((state_q == S_IDLE) && bus.start) begin
            lcode_q <= bus.code_in;
            lkey_q  <= bus.key;
        end
        if (state_q == S_DECODE) begin
            word_q <= word_d;
            if (cbyte_d != 8'd0) begin
                prev_q <= pbyte_d[5:0];
            end
        end else begin
            prev_q <= PREV_INIT;
        end
    end

    // Control FSM: vault bookkeeping, search/decode sequencing, registered status
    always_ff @(posedge msclk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            vld_q      <= '0;
            wptr_q     <= '0;
            idx_q      <= '0;
            bidx_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            code_out_q <= '0;
`ifdef ENIGMA_DEC_LOCKOUT_EN
            tries_q    <= 2'(MAX_TRIES);
            locked_q   <= 1'b0;
`endif
        end else begin
            // Writes land regardless of state; the pointer overwrites the oldest entry
            if (bus.store) begin
                vld_q[wptr_q] <= 1'b1;
                wptr_q        <= (wptr_q == LAST_IDX) ? '0 : wptr_q + 1'b1;
            end
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q <= S_SEARCH;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_SEARCH: begin
                    if (hit_d) begin
                        state_q <= S_DECODE;
                        bidx_q  <= 4'd9;
                    end else if (idx_q == LAST_IDX) begin
                        state_q    <= S_DONE;
                        done_q     <= 1'b1;
                        ok_q       <= 1'b0;
                        code_out_q <= '0;
`ifdef ENIGMA_DEC_LOCKOUT_EN
                        tries_q    <= tries_q - 2'd1;
                        if (tries_q == 2'd1) begin
                            locked_q <= 1'b1;
                        end
`endif
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_DECODE: begin
                    if (bidx_q == 4'd0) begin
                        state_q    <= S_DONE;
                        done_q     <= 1'b1;
                        ok_q       <= 1'b1;
                        code_out_q <= word_d;
`ifdef ENIGMA_DEC_LOCKOUT_EN
                        tries_q    <= 2'(MAX_TRIES);
`endif
                    end else begin
                        bidx_q <= bidx_q - 4'd1;
                    end
                end
                S_DONE: begin
                    busy_q <= 1'b0;
`ifdef ENIGMA_DEC_LOCKOUT_EN
                    state_q <= locked_q ? S_LOCKED : S_IDLE;
`else
                    state_q <= S_IDLE;
`endif
                end
`ifdef ENIGMA_DEC_LOCKOUT_EN
                S_LOCKED: begin
                    state_q <= S_LOCKED;
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.ok       = ok_q;
    assign bus.code_out = code_out_q;
`ifdef ENIGMA_DEC_LOCKOUT_EN
    assign bus.tries_left = tries_q;
    assign bus.locked     = locked_q;
`else
    assign bus.tries_left = 2'(MAX_TRIES);
    assign bus.locked     = 1'b0;
`endif
endmodule

// File: tb/tb_enigma_decoder.sv
// Bench for enigma_decoder: directed scenarios plus a randomized phase,
// with a scoreboard queue filled at issue time and drained by a monitor.
module tb_enigma_decoder;
    localparam int DEPTH     = 10;
    localparam int MAX_TRIES = 3;

    typedef struct {
        int          issue;
        int          lat;
        logic        ok;
        logic [79:0] code;
        logic [1:0]  tries;
        logic        locked;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   errors;
    int   checks;
    exp_t sbq[$];

    // Reference state: vault contents, pointer and failure bookkeeping
    logic        m_vld  [DEPTH];
    logic [79:0] m_code [DEPTH];
    logic [7:0]  m_key  [DEPTH];
    int          m_wptr;
    int          m_fail;
    logic        m_locked;

    enigma_decoder_if dut_if ();

    enigma_decoder #(.DEPTH(DEPTH), .MAX_TRIES(MAX_TRIES)) dut (
        .msclk (clk),
        .rst   (rst),
        .bus   (dut_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (dut_if.done === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("done_latency", 80'(cyc - e.issue), 80'(e.lat));
                chk("ok",           80'(dut_if.ok), 80'(e.ok));
                chk("code_out",     dut_if.code_out, e.code);
                chk("tries_left",   80'(dut_if.tries_left), 80'(e.tries));
                chk("locked",       80'(dut_if.locked), 80'(e.locked));
            end
        end
    end

    function automatic logic [79:0] model_decode(input logic [79:0] c, input logic [7:0] k);
        logic [79:0] r;
        int prev, cb, p;
        r = '0;
        prev = 5;
        for (int b = 9; b >= 0; b--) begin
            cb = int'(c[b*8 +: 8]);
            if (cb != 0) begin
                p = (((cb - prev - int'(k)) % 64) + 64) % 64;
                r[b*8 +: 8] = 8'(p);
                prev = p;
            end
        end
        return r;
    endfunction

    function automatic int model_search(input logic [79:0] c, input logic [7:0] k);
        for (int i = 0; i < DEPTH; i++) begin
            if (m_vld[i] && m_code[i] == c && m_key[i] == k) return i;
        end
        return -1;
    endfunction

    function automatic logic [79:0] rand_code();
        logic [79:0] r;
        for (int b = 0; b < 10; b++) begin
            r[b*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        end
        return r;
    endfunction

    task automatic cycle1();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
        m_wptr   = 0;
        m_fail   = 0;
        m_locked = 1'b0;
    endtask

    task automatic check_reset_values();
        chk("rst_busy",   80'(dut_if.busy), 80'(0));
        chk("rst_done",   80'(dut_if.done), 80'(0));
        chk("rst_ok",     80'(dut_if.ok), 80'(0));
        chk("rst_locked", 80'(dut_if.locked), 80'(0));
        chk("rst_code",   dut_if.code_out, 80'(0));
        chk("rst_tries",  80'(dut_if.tries_left), 80'(MAX_TRIES));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle1();
        rst = 1'b0;
        model_reset();
        sbq.delete();
        check_reset_values();
    endtask

    task automatic do_store(input logic [79:0] c, input logic [7:0] k);
        dut_if.store      = 1'b1;
        dut_if.store_code = c;
        dut_if.store_key  = k;
        cycle1();
        dut_if.store = 1'b0;
        m_vld[m_wptr]  = 1'b1;
        m_code[m_wptr] = c;
        m_key[m_wptr]  = k;
        m_wptr = (m_wptr + 1) % DEPTH;
    endtask

    task automatic raw_start(input logic [79:0] c, input logic [7:0] k);
        dut_if.start   = 1'b1;
        dut_if.code_in = c;
        dut_if.key     = k;
        cycle1();
        dut_if.start = 1'b0;
    endtask

    // Issue a decode request; the expectation is pushed before the pulse.
    // With ovr set, ok/code/latency come from the caller's constants.
    task automatic issue_start(input logic [79:0] c, input logic [7:0] k, input bit ovr,
                               input logic x_ok, input logic [79:0] x_code, input int x_lat);
        exp_t e;
        int   hit;
        bit   pushed;
        pushed = 0;
        if (!m_locked) begin
            hit = model_search(c, k);
            e.issue = cyc;
            if (ovr) begin
                e.ok = x_ok; e.code = x_code; e.lat = x_lat;
            end else if (hit >= 0) begin
                e.ok = 1'b1; e.code = model_decode(c, k); e.lat = 12 + hit;
            end else begin
                e.ok = 1'b0; e.code = '0; e.lat = 1 + DEPTH;
            end
`ifdef ENIGMA_DEC_LOCKOUT_EN
            if (e.ok) m_fail = 0;
            else m_fail++;
            if (m_fail >= MAX_TRIES) m_locked = 1'b1;
`endif
            e.tries  = 2'(MAX_TRIES - m_fail);
            e.locked = m_locked;
            sbq.push_back(e);
            pushed = 1;
        end
        raw_start(c, k);
        if (!pushed) repeat (25) cycle1();
    endtask

    task automatic wait_drain();
        bit drained;
        drained = 0;
        for (int i = 0; i < 60; i++) begin
            if (sbq.size() == 0 && dut_if.busy === 1'b0) begin
                drained = 1;
                break;
            end
            cycle1();
        end
        if (!drained) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0 pending", sbq.size());
            sbq.delete();
        end
        cycle1();
    endtask

    logic [79:0] wcode [11];
    logic [79:0] code_a, code_b, code_c, code_d;

    initial begin
        cyc = 0; errors = 0; checks = 0;
        rst = 1'b1;
        dut_if.store = 1'b0; dut_if.store_code = '0; dut_if.store_key = '0;
        dut_if.start = 1'b0; dut_if.code_in = '0; dut_if.key = '0;
        model_reset();
        repeat (3) cycle1();
        rst = 1'b0;
        check_reset_values();

        // Basic decode and zero-byte skip
        code_a = 80'h3723_0000_0000_0000_0000;
        code_b = 80'h3700_2300_0000_0000_0000;
        do_store(code_a, 8'h02);
        do_store(code_b, 8'h02);
        issue_start(code_a, 8'h02, 1, 1'b1, 80'h3031_0000_0000_0000_0000, 12);
        wait_drain();
        issue_start(code_b, 8'h02, 1, 1'b1, 80'h3000_3100_0000_0000_0000, 13);
        wait_drain();

        // Key mismatch, repeated until lockout (when compiled in)
        for (int i = 0; i < 4; i++) begin
            issue_start(code_a, 8'h03, 0, 1'b0, '0, 0);
            wait_drain();
        end
`ifdef ENIGMA_DEC_LOCKOUT_EN
        chk("locked_state_locked", 80'(dut_if.locked), 80'(1));
        chk("locked_state_busy",   80'(dut_if.busy), 80'(0));
        chk("locked_state_tries",  80'(dut_if.tries_left), 80'(0));
`else
        chk("nolock_locked", 80'(dut_if.locked), 80'(0));
        chk("nolock_tries",  80'(dut_if.tries_left), 80'(MAX_TRIES));
`endif

        // Vault wrap: eleventh store overwrites entry 0
        do_reset();
        for (int i = 0; i < 11; i++) begin
            wcode[i] = {8'(i + 1), 8'h40, 64'(i * 37 + 5)};
            do_store(wcode[i], 8'h11);
        end
        issue_start(wcode[0], 8'h11, 1, 1'b0, '0, 11);
        wait_drain();
        issue_start(wcode[10], 8'h11, 0, 1'b0, '0, 0);
        wait_drain();
        issue_start(wcode[1], 8'h11, 0, 1'b0, '0, 0);
        wait_drain();

        // Reset in the middle of a matching decode
        do_reset();
        do_store(code_a, 8'h02);
        raw_start(code_a, 8'h02);
        repeat (4) cycle1();
        do_reset();
        issue_start(code_a, 8'h02, 1, 1'b0, '0, 11);
        wait_drain();

        // Busy rules: start during SEARCH ignored, store during DECODE lands
        do_reset();
        for (int i = 0; i < 4; i++) do_store(rand_code(), 8'(i));
        code_c = 80'h1234_0056_789A_BC00_DEF1;
        code_d = 80'h4142_4344_0045_4647_4849;
        do_store(code_c, 8'h5A);
        issue_start(code_c, 8'h5A, 0, 1'b0, '0, 0);
        cycle1();
        chk("busy_in_search", 80'(dut_if.busy), 80'(1));
        raw_start(code_c, 8'h5A);
        repeat (5) cycle1();
        do_store(code_d, 8'h21);
        wait_drain();
        issue_start(code_d, 8'h21, 0, 1'b0, '0, 0);
        wait_drain();

        // Randomized traffic against the reference model
        do_reset();
        for (int it = 0; it < 60; it++) begin
            int sel, idx;
            logic [79:0] c;
            logic [7:0]  k;
            sel = int'($urandom_range(0, 9));
            if (sel < 4) begin
                do_store(rand_code(), 8'($urandom));
            end else begin
                idx = int'($urandom_range(0, DEPTH - 1));
                if (m_vld[idx] && sel < 9) begin
                    c = m_code[idx];
                    k = (sel == 8) ? m_key[idx] ^ 8'h01 : m_key[idx];
                end else begin
                    c = rand_code();
                    k = 8'($urandom);
                end
                issue_start(c, k, 0, 1'b0, '0, 0);
                wait_drain();
                if (m_locked) do_reset();
            end
        end

        repeat (3) cycle1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/enigma_decoder.md
# enigma_decoder

Sequential decryption engine for the Enigma encryptor board. It is the receive-side counterpart of the encryption path. A ciphertext is decoded only if it was previously registered, together with its key, in an internal 10-entry vault by the encryption side. Records are searched one per cycle and bytes are decoded one per cycle. A three-strike lockout protects the vault, and results feed the seven-segment and LED display logic.

## Interface
- `DEPTH`, default 10: number of vault entries.
- `MAX_TRIES`, default 3: consecutive failed attempts before lockout.
- `msclk` in 1: master clock, the only clock in the block.
- `rst` in 1: synchronous, active-high reset.
- `store` in 1: single-cycle pulse that writes `{store_code, store_key}` into the vault.
- `store_code` in 80: ciphertext to register.
- `store_key` in 8: key used for that ciphertext.
- `start` in 1: single-cycle request to decrypt `code_in` with `key`.
- `code_in` in 80: ciphertext, 10 bytes; byte 9 = [79:72], decoded first.
- `key` in 8: switch-supplied key (`hash_num`).
- `busy` out 1: high in SEARCH, DECODE and DONE.
- `done` out 1: one-cycle completion pulse.
- `ok` out 1: valid with `done`, held until the next `done`; 1 = authorized decode.
- `code_out` out 80: plaintext; 0 after a failed attempt.
- `tries_left` out 2: `MAX_TRIES` minus the consecutive failure count.
- `locked` out 1: lockout active.

## Operation
- Vault:
  - `DEPTH` entries of {valid, code[79:0], key[7:0]} plus a write pointer.
  - Each `store` writes the entry at the pointer and sets its valid bit. The pointer wraps 9→0, so the oldest entry is overwritten.
  - `store` is accepted in every state, including LOCKED.
- State machine: IDLE, SEARCH, DECODE, DONE, LOCKED.
- IDLE:
  - `start` latches `code_in` and `key`, sets index = 0, and moves to SEARCH.
  - `start` is ignored in every other state.
- SEARCH:
  - Each cycle examines one entry. A match requires valid, code equal to the latched code, and key equal to the latched key.
  - First match → DECODE. Entry `DEPTH-1` examined without a match → DONE with fail.
- DECODE, 10 cycles, one per byte from byte 9 down to byte 0:
  - `prev` is initialised to 5.
  - Ciphertext byte c == 0: output byte 0, `prev` unchanged.
  - Otherwise: p = (c − prev − key) mod 64, computed in 6-bit arithmetic and zero-extended to 8 bits. The output byte is p, then `prev` = p.
- DONE, one cycle: `done` = 1.
  - Success: `code_out` = decoded word, `ok` = 1, failure count cleared.
  - Failure: `code_out` = 0, `ok` = 0, failure count incremented.
  - Then → IDLE, or → LOCKED if the count has reached `MAX_TRIES`.
- LOCKED: absorbing state. Only `rst` leaves it; `busy` = 0 and `locked` = 1.
- `rst` wins over every other input in the same cycle:
  - state → IDLE, all valid bits and the write pointer cleared.
  - `busy`, `done`, `ok`, `locked` = 0; `code_out` = 0; `tries_left` = 3.
  - An operation in progress is discarded with no `done`.

## Timing
- `start` is sampled at edge T. Entry k is examined in the cycle starting at T+1+k.
- Match at entry k: DECODE occupies T+2+k … T+11+k and `done` is high at T+12+k. Best case is 12 cycles, worst case 21.
- Failure: `done` is high at T+1+`DEPTH` (T+11).
- `code_out`, `ok` and `tries_left` update on the edge that raises `done`. `locked` rises on the same edge as the third failing `done`.
- `store` in the same cycle that SEARCH examines the written entry: the search sees the old contents. The new value is visible the following cycle.
- `start` in the DONE cycle is ignored. The earliest accepted `start` is in the cycle after `done`.

## Configuration
- `ENIGMA_DEC_LOCKOUT_EN` defined:
  - Failure counting, `tries_left` decrement and the LOCKED state are compiled in, as described above.
- Not defined:
  - The LOCKED state is removed and `locked` is tied to 0.
  - `tries_left` stays at 3.
  - Failures only produce `done` with `ok` = 0 and `code_out` = 0.

## Test plan
- Basic decode:
  - Stimulus: `store` code 80'h3723_0000_0000_0000_0000 with key 8'h02, then `start` with the same code and key.
  - Required: `done` at T+12, `ok` = 1, `code_out` = 80'h3031_0000_0000_0000_0000.
- Zero-byte skip:
  - Stimulus: store and start code 80'h3700_2300_0000_0000_0000 with key 8'h02.
  - Required: `code_out` = 80'h3000_3100_0000_0000_0000.
- Key mismatch and lockout, macro defined:
  - Stimulus: three starts with the stored code but key 8'h03.
  - Required: each `done` at T+11 with `ok` = 0 and `code_out` = 0. `tries_left` goes 2, 1, 0; `locked` = 1 after the third; a fourth `start` produces no `done`.
  - Macro undefined: the same stimulus never locks and `tries_left` stays 3.
- Vault wrap:
  - Stimulus: 11 stores with distinct codes, then start with the first code.
  - Required: fail at T+11. Starting with the eleventh code matches entry 0 (`done` at T+12); starting with the second code matches entry 1 (`done` at T+13).
- Reset mid-DECODE:
  - Stimulus: assert `rst` at T+5 of a matching decode, then start with the same code.
  - Required: no `done` from the interrupted decode; all outputs at reset values; the new start fails because the vault was cleared.
- Busy rules:
  - Stimulus: `start` pulsed during SEARCH; `store` pulsed during DECODE.
  - Required: the second `start` is ignored, exactly one `done` occurs, and the store succeeds, proven by a later successful decode of that code.
